// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and field positions for the instruction fetch stage
package fetch_pkg;

    localparam int OPCODE_MSB    = 31;
    localparam int OPCODE_LSB    = 26;
    localparam int OPCODE_W      = 6;
    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of fetched {instr, pc} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
        if (rst_n) assert (!(push_i && full_o));
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, instruction memory request FSM and decode-facing output buffer
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                INSTR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PC_STEP    = 4,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_target,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [OPCODE_W-1:0] if_opcode
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              gnt_ok;
    logic              space_after_push;

    assign if_valid   = !fifo_empty;
    assign pop        = if_valid && if_ready;
    assign if_instr   = if_valid ? head.instr : '0;
    assign if_pc      = if_valid ? head.pc : '0;
    assign if_opcode  = if_instr[OPCODE_MSB:OPCODE_LSB];
    assign imem_addr  = pc_q;
    assign imem_req   = (state_q == REQ) && !fifo_full;
    assign gnt_ok     = imem_req && imem_gnt;
    assign push_entry = '{instr: imem_rdata, pc: req_pc_q};

    // A returning word leaves room for another request only if the buffer is not left full.
    assign space_after_push = pop || (fifo_count < CNT_W'(FIFO_DEPTH - 1));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_target;
            case (state_q)
                REQ:           state_d = gnt_ok ? DISCARD : REQ;
                WAIT, DISCARD: state_d = imem_rvalid ? REQ : DISCARD;
                default:       state_d = REQ;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (gnt_ok) begin
                        pc_d     = pc_q + ADDR_W'(PC_STEP);
                        req_pc_d = pc_q;
                        state_d  = WAIT;
                    end else if (fifo_full) begin
                        state_d = HOLD;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        push    = 1'b1;
                        state_d = space_after_push ? REQ : HOLD;
                    end
                end
                HOLD:    if (!fifo_full || pop) state_d = REQ;
                DISCARD: if (imem_rvalid) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .head_o       (head),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed scoreboard bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [5:0]  if_opcode;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        gnt_en;
    int          lat;
    logic        pend;
    logic [31:0] paddr;
    int          wcnt;
    logic [31:0] exp_q[$];
    int          hs_cyc[$];
    logic [31:0] mon_exp;
    logic [31:0] mon_word;
    int          bad;
    int          reqs;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_opcode       (if_opcode)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2] ^ 6'b001001, a[25:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory: grant when enabled, one response lat cycles after the cycle following the grant.
    assign imem_gnt    = gnt_en;
    assign imem_rvalid = pend && (wcnt == 0);
    assign imem_rdata  = imem_rvalid ? mem_word(paddr) : 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            wcnt  <= 0;
            paddr <= 32'h0;
        end else if (imem_req && imem_gnt) begin
            pend  <= 1'b1;
            paddr <= imem_addr;
            wcnt  <= lat;
        end else if (imem_rvalid) begin
            pend <= 1'b0;
        end else if (pend) begin
            wcnt <= wcnt - 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        #2;
        if (rst_n && if_valid && if_ready) begin
            mon_exp  = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            mon_word = mem_word(mon_exp);
            hs_cyc.push_back(cyc);
            check("hs_pc", if_pc, mon_exp);
            check("hs_instr", if_instr, mon_word);
            check("hs_opcode", {26'd0, if_opcode}, {26'd0, mon_word[31:26]});
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        if_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if_ready = 1'b0;
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_req(input bit need_gnt, input string tag);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (imem_req && (!need_gnt || imem_gnt)) break;
        end
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        gnt_en = 1'b1;
        lat = 0;
        if_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_opcode", {26'd0, if_opcode}, 32'd0);

        // Sequential fetch at zero wait
        rst_n = 1'b1;
        check("c0_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("c1_req", {31'd0, imem_req}, 32'd1);
        check("c1_addr", imem_addr, 32'h0);
        hs_cyc.delete();
        exp_q = '{32'h0, 32'h4, 32'h8};
        drain("t1");
        check("t1_hs_count", 32'(hs_cyc.size()), 32'd3);
        if (hs_cyc.size() >= 3) begin
            check("t1_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
            check("t1_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
        end

        // Backpressure fills the buffer and stops requests
        bad = 0;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2 && (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== mem_word(32'hC))) bad++;
            if (i >= 3 && imem_req) reqs++;
        end
        check("t2_head_stable", 32'(bad), 32'd0);
        check("t2_req_low", 32'(reqs), 32'd0);
        check("t2_head_pc", if_pc, 32'hC);
        exp_q = '{32'hC, 32'h10, 32'h14, 32'h18};
        drain("t2");

        // Redirect while a request is outstanding
        lat = 2;
        wait_req(1'b1, "t3_find");
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t3_flushed", {31'd0, if_valid}, 32'd0);
        wait_req(1'b0, "t3_restart");
        check("t3_addr", imem_addr, 32'h100);
        lat = 0;
        exp_q = '{32'h100, 32'h104};
        drain("t3");

        // Redirect before grant changes the presented address
        gnt_en = 1'b0;
        wait_req(1'b0, "t4_find");
        @(negedge clk);
        check("t4_req_hold", {31'd0, imem_req}, 32'd1);
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t4_req_after", {31'd0, imem_req}, 32'd1);
        check("t4_addr", imem_addr, 32'h40);
        check("t4_flushed", {31'd0, if_valid}, 32'd0);
        gnt_en = 1'b1;
        @(posedge clk);
        #1;
        check("t4_pc_after_gnt", imem_addr, 32'h44);
        exp_q = '{32'h40, 32'h44};
        drain("t4");

        // Redirect coincident with the response
        wait_req(1'b1, "t5a_find");
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t5a_flushed", {31'd0, if_valid}, 32'd0);
        check("t5a_req", {31'd0, imem_req}, 32'd1);
        check("t5a_addr", imem_addr, 32'h200);
        exp_q = '{32'h200, 32'h204};
        drain("t5a");

        // Redirect coincident with a decode handshake on a full buffer
        repeat (8) @(negedge clk);
        check("t5b_full_valid", {31'd0, if_valid}, 32'd1);
        check("t5b_head_pc", if_pc, 32'h208);
        exp_q = '{32'h208, 32'h300, 32'h304};
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t5b_flushed", {31'd0, if_valid}, 32'd0);
        check("t5b_hs_once", 32'(exp_q.size()), 32'd2);
        drain("t5b");

        // Asynchronous reset with a request outstanding
        lat = 2;
        wait_req(1'b1, "t6_find");
        @(negedge clk);
        check("t6_pre_valid", {31'd0, if_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_req", {31'd0, imem_req}, 32'd0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_valid", {31'd0, if_valid}, 32'd0);
        check("t6_pc", if_pc, 32'h0);
        check("t6_instr", if_instr, 32'h0);
        check("t6_opcode", {26'd0, if_opcode}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        @(posedge clk);
        #1;
        check("t6_restart_req", {31'd0, imem_req}, 32'd1);
        check("t6_restart_addr", imem_addr, 32'h0);
        exp_q = '{32'h0, 32'h4};
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
